// File: rtl/pc_fetch_stage_pkg.sv
// pc_fetch_stage_pkg: fetch FSM encoding and PC alignment constant shared by the fetch stage
package pc_fetch_stage_pkg;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} fetch_state_t;
   localparam int unsigned PC_ALIGN_MASK = 32'd3;
endpackage

// File: rtl/mux_bus_2_1.sv
// mux_bus_2_1: two-input bus multiplexer, s_i selects in_b_i
module mux_bus_2_1 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   input  logic             s_i,
   output logic [WIDTH-1:0] out_o
);
   assign out_o = s_i ? in_b_i : in_a_i;
endmodule

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: owns the PC, keeps one imem request in flight and hands {pc, instr} to decode
// over valid/ready; redirects override everything and squash any stale fetch.
module pc_fetch_stage
   import pc_fetch_stage_pkg::*;
#(
   parameter int unsigned          BUS_WIDTH = 32,
   parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0,
   parameter int unsigned          PC_STEP   = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 redirect_valid_i,
   input  logic [BUS_WIDTH-1:0] redirect_pc_i,
   output logic                 imem_req_o,
   output logic [BUS_WIDTH-1:0] imem_addr_o,
   input  logic                 imem_gnt_i,
   input  logic                 imem_rvalid_i,
   input  logic [BUS_WIDTH-1:0] imem_rdata_i,
   output logic                 if_valid_o,
   input  logic                 if_ready_i,
   output logic [BUS_WIDTH-1:0] if_pc_o,
   output logic [BUS_WIDTH-1:0] if_instr_o
);
   fetch_state_t         state_q, state_d;
   logic                 drop_q, drop_d;
   logic [BUS_WIDTH-1:0] pc_q, fetch_pc_q, if_pc_q, if_instr_q;
   logic [BUS_WIDTH-1:0] pc_inc, redirect_tgt, next_pc;
   logic                 grant, resp, pc_en, load_instr;

   assign redirect_tgt = redirect_pc_i & ~BUS_WIDTH'(PC_ALIGN_MASK);
   assign pc_inc       = pc_q + BUS_WIDTH'(PC_STEP);

   mux_bus_2_1 #(.WIDTH(BUS_WIDTH)) u_next_pc (
      .in_a_i(pc_inc),
      .in_b_i(redirect_tgt),
      .s_i   (redirect_valid_i),
      .out_o (next_pc)
   );

   assign grant      = (state_q == S_REQ) && imem_gnt_i;
   assign resp       = (state_q == S_WAIT) && imem_rvalid_i;
   assign pc_en      = redirect_valid_i || grant;
   assign load_instr = resp && !drop_q && !redirect_valid_i;

   // drop marks an in-flight request made stale by a redirect; its response is swallowed
   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      case (state_q)
         S_IDLE:  state_d = S_REQ;
         S_REQ:   state_d = imem_gnt_i ? S_WAIT : S_REQ;
         S_WAIT:  state_d = !imem_rvalid_i ? S_WAIT : (load_instr ? S_HOLD : S_REQ);
         S_HOLD:  state_d = (if_ready_i || redirect_valid_i) ? S_REQ : S_HOLD;
         default: state_d = S_IDLE;
      endcase
      if (resp)
         drop_d = 1'b0;
      else if (redirect_valid_i && (grant || state_q == S_WAIT))
         drop_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q       <= RESET_PC;
         fetch_pc_q <= RESET_PC;
         if_pc_q    <= '0;
         if_instr_q <= '0;
      end else begin
         if (pc_en) pc_q <= next_pc;
         if (grant) fetch_pc_q <= pc_q;
         if (load_instr) begin
            if_pc_q    <= fetch_pc_q;
            if_instr_q <= imem_rdata_i;
         end
      end
   end

   assign imem_req_o  = state_q == S_REQ;
   assign imem_addr_o = pc_q;
   assign if_valid_o  = state_q == S_HOLD;
   assign if_pc_o     = if_pc_q;
   assign if_instr_o  = if_instr_q;

   a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      if_valid_o && !if_ready_i |=> $stable(if_pc_o) && $stable(if_instr_o));
endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: scoreboard bench; expected PCs are queued at grant time and popped at decode handshake
module tb_pc_fetch_stage;
   localparam int W = 32;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         redirect_valid_i = 1'b0;
   logic [W-1:0] redirect_pc_i = '0;
   logic         imem_req_o;
   logic [W-1:0] imem_addr_o;
   logic         imem_gnt_i = 1'b0;
   logic         imem_rvalid_i = 1'b0;
   logic [W-1:0] imem_rdata_i = '0;
   logic         if_valid_o;
   logic         if_ready_i = 1'b0;
   logic [W-1:0] if_pc_o;
   logic [W-1:0] if_instr_o;

   pc_fetch_stage dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .if_valid_o(if_valid_o), .if_ready_i(if_ready_i),
      .if_pc_o(if_pc_o), .if_instr_o(if_instr_o)
   );

   always #5 clk_i = ~clk_i;

   int           n_chk = 0, n_pass = 0, n_hs = 0, last_ticks = 0;
   int           gnt_pct = 100, rv_pct = 100, rdy_pct = 100;
   logic         ovr_en = 1'b0;
   logic [W-1:0] ovr_data = '0;
   logic [W-1:0] model_next = '0;
   logic [W-1:0] pend_q[$];
   logic [W-1:0] exp_q[$];

   function automatic logic [W-1:0] instr_of(input logic [W-1:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic tick(input logic redir, input logic [W-1:0] tgt);
      logic [W-1:0] e;
      @(negedge clk_i);
      redirect_valid_i = redir;
      redirect_pc_i    = tgt;
      imem_gnt_i       = imem_req_o && (int'($urandom_range(99)) < gnt_pct);
      imem_rvalid_i    = (pend_q.size() != 0) && (int'($urandom_range(99)) < rv_pct);
      imem_rdata_i     = '0;
      if (imem_rvalid_i) begin
         imem_rdata_i = ovr_en ? ovr_data : instr_of(pend_q[0]);
         void'(pend_q.pop_front());
      end
      if_ready_i = int'($urandom_range(99)) < rdy_pct;
      if (imem_req_o && imem_gnt_i) begin
         pend_q.push_back(imem_addr_o);
         n_chk++;
         if (imem_addr_o !== model_next) $display("FAIL imem_addr: got %h expected %h", imem_addr_o, model_next);
         else n_pass++;
         exp_q.push_back(model_next);
         model_next += W'(4);
      end
      if (if_valid_o && if_ready_i && !redir) begin
         n_hs++;
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_handoff: got pc %h, none expected", if_pc_o);
         end else begin
            e = exp_q.pop_front();
            n_chk += 2;
            if (if_pc_o !== e) $display("FAIL if_pc: got %h expected %h", if_pc_o, e);
            else n_pass++;
            if (if_instr_o !== instr_of(e)) $display("FAIL if_instr: got %h expected %h", if_instr_o, instr_of(e));
            else n_pass++;
         end
      end
      if (redir) begin
         exp_q.delete();
         model_next = tgt & ~32'h3;
      end
      @(posedge clk_i);
      #1;
      redirect_valid_i = 1'b0;
   endtask

   task automatic run_hs(input int n);
      int target, t;
      target = n_hs + n;
      t = 0;
      while (n_hs < target && t < 60 * n) begin
         tick(1'b0, '0);
         t++;
      end
      last_ticks = t;
      if (n_hs < target) begin
         n_chk++;
         $display("FAIL handoff_timeout: got %0d handoffs expected %0d", n_hs, target);
      end
   endtask

   task automatic goto_req();
      int t;
      gnt_pct = 0; rv_pct = 100; rdy_pct = 100;
      t = 0;
      while (!imem_req_o && t < 20) begin
         tick(1'b0, '0);
         t++;
      end
      if (!imem_req_o) begin
         n_chk++;
         $display("FAIL goto_req_timeout: imem_req %b expected 1", imem_req_o);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      n_chk += 5;
      if (imem_req_o !== 1'b0) $display("FAIL rst_req: got %b expected 0", imem_req_o); else n_pass++;
      if (imem_addr_o !== 32'h0) $display("FAIL rst_addr: got %h expected 0", imem_addr_o); else n_pass++;
      if (if_valid_o !== 1'b0) $display("FAIL rst_valid: got %b expected 0", if_valid_o); else n_pass++;
      if (if_pc_o !== 32'h0) $display("FAIL rst_pc: got %h expected 0", if_pc_o); else n_pass++;
      if (if_instr_o !== 32'h0) $display("FAIL rst_instr: got %h expected 0", if_instr_o); else n_pass++;
      rst_ni = 1'b1;
      model_next = '0;
      @(posedge clk_i);
      #1;
      n_chk++;
      if (imem_req_o !== 1'b1) $display("FAIL first_req: got %b expected 1", imem_req_o); else n_pass++;
   endtask

   task automatic test_sequential();
      gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
      run_hs(3);
      n_chk++;
      if (last_ticks !== 9) $display("FAIL seq_cycles: got %0d expected 9", last_ticks); else n_pass++;
   endtask

   task automatic test_backpressure();
      int t;
      goto_req();
      gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
      t = 0;
      while (!if_valid_o && t < 10) begin
         tick(1'b0, '0);
         t++;
      end
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, '0);
         n_chk += 3;
         if (if_valid_o !== 1'b1 || imem_req_o !== 1'b0)
            $display("FAIL bp_state: got valid %b req %b expected 1 0", if_valid_o, imem_req_o);
         else n_pass++;
         if (exp_q.size() == 0 || if_pc_o !== exp_q[0])
            $display("FAIL bp_pc: got %h expected queued pc (queue size %0d)", if_pc_o, exp_q.size());
         else n_pass++;
         if (exp_q.size() == 0 || if_instr_o !== instr_of(exp_q[0]))
            $display("FAIL bp_instr: got %h expected instr of queued pc", if_instr_o);
         else n_pass++;
      end
      rdy_pct = 100;
      run_hs(1);
   endtask

   task automatic test_redirect_wait();
      goto_req();
      gnt_pct = 100; rv_pct = 0;
      tick(1'b0, '0);
      gnt_pct = 0;
      tick(1'b1, 32'h100);
      ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF; rv_pct = 100;
      tick(1'b0, '0);
      ovr_en = 1'b0;
      n_chk += 2;
      if (imem_req_o !== 1'b1 || if_valid_o !== 1'b0)
         $display("FAIL rw_state: got req %b valid %b expected 1 0", imem_req_o, if_valid_o);
      else n_pass++;
      if (imem_addr_o !== 32'h100) $display("FAIL rw_addr: got %h expected 00000100", imem_addr_o); else n_pass++;
      gnt_pct = 100; rdy_pct = 100;
      run_hs(1);
   endtask

   task automatic test_redirect_gnt();
      goto_req();
      gnt_pct = 100; rv_pct = 0;
      tick(1'b1, 32'h203);
      n_chk++;
      if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0)
         $display("FAIL rg_wait: got req %b valid %b expected 0 0", imem_req_o, if_valid_o);
      else n_pass++;
      gnt_pct = 0; rv_pct = 100;
      tick(1'b0, '0);
      n_chk += 2;
      if (imem_req_o !== 1'b1 || if_valid_o !== 1'b0)
         $display("FAIL rg_state: got req %b valid %b expected 1 0", imem_req_o, if_valid_o);
      else n_pass++;
      if (imem_addr_o !== 32'h200) $display("FAIL rg_addr: got %h expected 00000200", imem_addr_o); else n_pass++;
      gnt_pct = 100;
      run_hs(1);
   endtask

   task automatic test_wrap();
      goto_req();
      tick(1'b1, 32'hFFFF_FFFC);
      n_chk++;
      if (imem_addr_o !== 32'hFFFF_FFFC) $display("FAIL wrap_tgt: got %h expected fffffffc", imem_addr_o); else n_pass++;
      gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
      run_hs(1);
      n_chk++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0)
         $display("FAIL wrap_addr: got req %b addr %h expected 1 00000000", imem_req_o, imem_addr_o);
      else n_pass++;
      run_hs(1);
   endtask

   task automatic test_reset_mid_fetch();
      goto_req();
      gnt_pct = 100; rv_pct = 0;
      tick(1'b0, '0);
      #2;
      rst_ni = 1'b0;
      #1;
      exp_q.delete();
      model_next = '0;
      n_chk += 2;
      if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0)
         $display("FAIL arst_state: got req %b valid %b expected 0 0", imem_req_o, if_valid_o);
      else n_pass++;
      if (imem_addr_o !== 32'h0) $display("FAIL arst_addr: got %h expected 0", imem_addr_o); else n_pass++;
      repeat (2) tick(1'b0, '0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      gnt_pct = 0; rv_pct = 100;
      tick(1'b0, '0);
      n_chk += 2;
      if (imem_req_o !== 1'b1 || if_valid_o !== 1'b0)
         $display("FAIL late_rvalid_state: got req %b valid %b expected 1 0", imem_req_o, if_valid_o);
      else n_pass++;
      if (imem_addr_o !== 32'h0) $display("FAIL late_rvalid_addr: got %h expected 0", imem_addr_o); else n_pass++;
      gnt_pct = 100; rdy_pct = 100;
      run_hs(2);
   endtask

   task automatic test_random();
      int hs0;
      hs0 = n_hs;
      for (int b = 0; b < 12; b++) begin
         gnt_pct = int'($urandom_range(90, 20));
         rv_pct  = int'($urandom_range(90, 20));
         rdy_pct = int'($urandom_range(90, 20));
         for (int i = 0; i < 50; i++)
            tick(int'($urandom_range(99)) < 4, $urandom);
      end
      gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
      run_hs(2);
      n_chk++;
      if (n_hs - hs0 < 40) $display("FAIL rand_progress: got %0d handoffs expected at least 40", n_hs - hs0);
      else n_pass++;
   endtask

   task automatic watchdog();
      #2_000_000;
      $display("FAIL watchdog: run still active at time %0t", $time);
      $fatal(1, "watchdog expired");
   endtask

   initial watchdog();

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_wait();
      test_redirect_gnt();
      test_wrap();
      test_reset_mid_fetch();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
